// File: rtl/ibus_loader_pkg.sv
// Shared definitions for the instruction-bus loader: default widths and
// the loader FSM state encoding.
package ibus_loader_pkg;

   localparam int unsigned IBUS_DW = 16;
   localparam int unsigned IBUS_AW = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } ld_state_e;

endpackage

// File: rtl/ibus_ram.sv
// Instruction storage: one write port and one synchronous read port.
// The read address is registered so the array maps onto block RAM.
// Contents are never reset.
module ibus_ram
   import ibus_loader_pkg::*;
#(
   parameter int unsigned DW = IBUS_DW,
   parameter int unsigned AW = IBUS_AW
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(2**AW)-1];
   logic [AW-1:0] raddr_q;

   // Write port, plus read address capture; the address holds when no read is issued so stalls keep rdata stable
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         raddr_q <= raddr;
      end
   end

   assign rdata = mem[raddr_q];

endmodule

// File: rtl/ibus_loader.sv
// Instruction memory with a streaming loader and a fetch pipeline.
// While a load session is active, fetches are ignored and flushed, so
// reads and writes never meet on the same cycle.
module ibus_loader
   import ibus_loader_pkg::*;
#(
   parameter int unsigned DW   = IBUS_DW,
   parameter int unsigned AW   = IBUS_AW,
   parameter int unsigned OREG = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   input  logic          f_stall,
   output logic [DW-1:0] f_dout,
   output logic          f_valid,
   input  logic          l_start,
   input  logic [AW-1:0] l_base,
   input  logic [AW:0]   l_len,
   input  logic          l_valid,
   input  logic [DW-1:0] l_data,
   output logic          l_ready,
   output logic          l_busy,
   output logic          l_done
);

   ld_state_e     state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          v1_q, v1_d;
   logic          we_s;
   logic          accept_s;
   logic          flush_s;
   logic [DW-1:0] rd_data_s;

   // Loader next-state, write strobe and address/count bookkeeping
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      we_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (l_start) begin
               addr_d = l_base;
               cnt_d  = l_len;
               if (l_len == {(AW+1){1'b0}}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (l_valid && !rst) begin
               we_s   = 1'b1;
               addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
               cnt_d  = cnt_q - {{AW{1'b0}}, 1'b1};
               if (cnt_q == {{AW{1'b0}}, 1'b1}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d = (state_d == ST_LOAD);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   // First fetch stage: accept when idle and unstalled, flush whenever a session is (about to be) active
   always_comb begin
      accept_s = f_req & ~f_stall & ~busy_q;
      flush_s  = (state_d != ST_IDLE);
      if (flush_s) begin
         v1_d = 1'b0;
      end else if (f_stall) begin
         v1_d = v1_q;
      end else begin
         v1_d = accept_s;
      end
   end

   // Loader and first fetch stage registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= {AW{1'b0}};
         cnt_q   <= {(AW+1){1'b0}};
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         v1_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         v1_q    <= v1_d;
      end
   end

   ibus_ram #(.DW(DW), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (we_s),
      .waddr (addr_q),
      .wdata (l_data),
      .re    (accept_s),
      .raddr (f_addr),
      .rdata (rd_data_s)
   );

   assign l_ready = ready_q;
   assign l_busy  = busy_q;
   assign l_done  = done_q;

   if (OREG != 0) begin : g_oreg
      logic          v2_q, v2_d;
      logic [DW-1:0] d2_q, d2_d;

      // Output stage: advances with the pipeline, holds on stall, zero data when the slot is empty
      always_comb begin
         if (flush_s) begin
            v2_d = 1'b0;
            d2_d = {DW{1'b0}};
         end else if (f_stall) begin
            v2_d = v2_q;
            d2_d = d2_q;
         end else begin
            v2_d = v1_q;
            d2_d = v1_q ? rd_data_s : {DW{1'b0}};
         end
      end

      // Output stage registers with synchronous reset
      always_ff @(posedge clk) begin
         if (rst) begin
            v2_q <= 1'b0;
            d2_q <= {DW{1'b0}};
         end else begin
            v2_q <= v2_d;
            d2_q <= d2_d;
         end
      end

      assign f_valid = v2_q;
      assign f_dout  = d2_q;
   end else begin : g_noreg
      assign f_valid = v1_q;
      assign f_dout  = v1_q ? rd_data_s : {DW{1'b0}};
   end

endmodule

// File: doc/ibus_loader.md
IBUS_LOADER -- requirements
Module: ibus_loader

Interface
REQ-001 Parameter DW, default 16: instruction word width in bits.
REQ-002 Parameter AW, default 16: address width; depth is 2**AW words.
REQ-003 Parameter OREG, default 0: 0 gives 1-cycle fetch latency; 1 adds an output register for 2-cycle latency.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 f_req  input  1  fetch request; f_addr is sampled this cycle.
REQ-007 f_addr  input  AW  fetch word address.
REQ-008 f_stall  input  1  consumer stall; freezes the fetch pipeline.
REQ-009 f_dout  output  DW  fetched instruction word.
REQ-010 f_valid  output  1  f_dout is valid.
REQ-011 l_start  input  1  one-cycle pulse that starts a load session.
REQ-012 l_base  input  AW  first write address, sampled with l_start.
REQ-013 l_len  input  AW+1  number of words to load, sampled with l_start.
REQ-014 l_valid  input  1  l_data is offered.
REQ-015 l_data  input  DW  word to write.
REQ-016 l_ready  output  1  loader accepts l_data; a transfer occurs when l_valid and l_ready are both high.
REQ-017 l_busy  output  1  a load session is active.
REQ-018 l_done  output  1  one-cycle pulse when the session completes.

Function
REQ-019 Storage SHALL be a 2**AW x DW array with no reset of contents, inferable as BRAM (synchronous read address register).
REQ-020 Loader FSM states SHALL be IDLE, LOAD and DONE; reset state is IDLE.
REQ-021 IDLE->LOAD SHALL occur on l_start with l_len!=0; IDLE->DONE SHALL occur on l_start with l_len==0; l_start outside IDLE SHALL be ignored.
REQ-022 In LOAD, l_ready SHALL be 1; each transfer SHALL write l_data to the current address, increment the address modulo 2**AW (wrap FFFF->0000 at AW=16), and decrement the remaining count.
REQ-023 The transfer that brings the remaining count to 0 SHALL cause LOAD->DONE.
REQ-024 DONE SHALL last exactly one cycle with l_done=1, then return to IDLE.
REQ-025 l_busy SHALL be 1 in LOAD and DONE; l_ready SHALL be 0 outside LOAD.
REQ-026 While l_busy=1, f_req SHALL be ignored, f_valid SHALL be 0, and any in-flight fetch SHALL be discarded; no read/write collision is therefore possible.
REQ-027 OREG=0: f_req accepted at cycle N (not stalled, not busy) SHALL give f_valid=1 and f_dout=mem[f_addr] at N+1.
REQ-028 OREG=1: the same SHALL appear at N+2; the pipeline SHALL accept one request per cycle.
REQ-029 f_stall=1 SHALL hold f_dout, f_valid and all internal fetch stages unchanged, with f_req not accepted that cycle; back-to-back stalls hold indefinitely.
REQ-030 Cycles with no accepted f_req SHALL produce f_valid=0 at the corresponding output slot.
REQ-031 f_dout SHALL be forced to 0 whenever f_valid=0.

Reset
REQ-032 rst SHALL set: FSM=IDLE, l_ready=0, l_busy=0, l_done=0, f_valid=0, f_dout=0, and load address/count=0.
REQ-033 rst during LOAD SHALL abort the session with no l_done pulse; words already written SHALL remain in memory.
REQ-034 rst SHALL take priority over l_start, f_req and f_stall in the same cycle.

Structure
REQ-035 Shared package SHALL hold the FSM state encoding (IDLE=0, LOAD=1, DONE=2, 2 bits) and defaults DW=16, AW=16.
REQ-036 The storage array with its registered read address SHALL be the sub-module ibus_ram (one write port, one synchronous read port); the FSM and fetch pipeline SHALL live in ibus_loader.

Verification
REQ-037 Load l_base=0x0010, l_len=3, data A1,B2,C3 with a 1-cycle l_valid gap -> mem[10..12]=A1,B2,C3; l_done pulses exactly once, one cycle after the 3rd transfer.
REQ-038 Load l_base=0xFFFF, l_len=2 -> mem[FFFF]=first word, mem[0000]=second word (wrap).
REQ-039 l_start with l_len=0 -> l_busy=1 and l_done=1 for one cycle, no write, l_ready stays 0.
REQ-040 OREG=0 and OREG=1: f_req to 0x0010,0x0011,0x0012 on consecutive cycles -> A1,B2,C3 with f_valid at latency 1 and 2 respectively; f_stall held 2 cycles mid-stream freezes the output, then the sequence resumes with no loss or duplication.
REQ-041 Assert rst after the 2nd transfer of a 3-word load -> all outputs 0 next cycle, no l_done, and a later fetch of the 2nd address returns the written word.
REQ-042 f_req asserted during LOAD -> f_valid stays 0 throughout the session and f_dout=0.
